// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction prefetch unit.
// Holds the NOP filler, the default boot PC and the buffer entry layout.
package fetch_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] START_ADDR_DEFAULT = 32'h2000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_prefetch_if.sv
// Bus bundle between the prefetch unit, the MMU and the decoder.
// master: prefetch side (drives requests and fetch outputs); slave: environment side.
interface fetch_prefetch_if;

  logic        FLUSH;
  logic [31:0] FLUSH_PC;
  logic        STALL;
  logic        MEM_WAIT;
  logic        INST_RDEN;
  logic [31:0] INST_RIADDR;
  logic        INST_RVALID;
  logic [31:0] INST_ROADDR;
  logic [31:0] INST_RDATA;
  logic        FETCH_VALID;
  logic [31:0] FETCH_PC;
  logic [31:0] FETCH_INST;
  logic        PROTO_ERR;

  modport master (
    input  FLUSH, FLUSH_PC, STALL, MEM_WAIT,
    input  INST_RVALID, INST_ROADDR, INST_RDATA,
    output INST_RDEN, INST_RIADDR,
    output FETCH_VALID, FETCH_PC, FETCH_INST, PROTO_ERR
  );

  modport slave (
    output FLUSH, FLUSH_PC, STALL, MEM_WAIT,
    output INST_RVALID, INST_ROADDR, INST_RDATA,
    input  INST_RDEN, INST_RIADDR,
    input  FETCH_VALID, FETCH_PC, FETCH_INST, PROTO_ERR
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous prefetch buffer: push/pop/clear, occupancy count out.
// Ports: clk, rst, push, pop, clear, din -> dout (head), count.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // DEPTH is a power of two, so pointers wrap by natural overflow
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (clear) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q] = din;
        wr_d = wr_q + PW'(1);
      end
      if (pop) begin
        rd_d = rd_q + PW'(1);
      end
      if (push && !pop) begin
        cnt_d = cnt_q + CW'(1);
      end else if (pop && !push) begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end

  assign dout  = mem_q[rd_q];
  assign count = cnt_q;

endmodule

// File: rtl/fetch_prefetch.sv
// Instruction prefetch: issues sequential fetches, buffers responses in order.
// Ports: CLK, RST, bus (master: requests to MMU, fetch head to decoder, PROTO_ERR).
module fetch_prefetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] START_ADDR      = START_ADDR_DEFAULT,
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic CLK,
  input  logic RST,
  fetch_prefetch_if.master bus
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int OW = $clog2(DEPTH + 1);

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   last_pc_q, last_pc_d;
  logic [CW-1:0] inflt_q, inflt_d;
  logic [CW-1:0] disc_q, disc_d;
  logic          proto_err_q, proto_err_d;

  logic [OW-1:0] occ;
  fetch_entry_t  head;
  fetch_entry_t  push_ent;
  logic          rden, accept, rsp_ok;
  logic          push, pop, valid;

  // Credit: buffered + in-flight never exceeds DEPTH, so a push always fits
  assign rden = !RST && !bus.FLUSH
             && ((int'(occ) + int'(inflt_q)) < DEPTH)
             && (int'(inflt_q) < MAX_OUTSTANDING);

  assign accept   = rden && !bus.MEM_WAIT;
  assign rsp_ok   = bus.INST_RVALID && (inflt_q != '0);
  assign push     = rsp_ok && (disc_q == '0) && !bus.FLUSH;
  assign valid    = (occ != '0);
  assign pop      = valid && !bus.STALL && !bus.FLUSH;
  assign push_ent = '{pc: bus.INST_ROADDR, inst: bus.INST_RDATA};

  always_comb begin
    pc_d        = pc_q;
    last_pc_d   = last_pc_q;
    inflt_d     = inflt_q + CW'(accept) - CW'(rsp_ok);
    disc_d      = disc_q;
    proto_err_d = proto_err_q;
    if (bus.FLUSH) begin
      pc_d = bus.FLUSH_PC;
    end else if (accept) begin
      pc_d = pc_q + 32'd4;
    end
    // Responses still owed for pre-flush requests must be thrown away
    if (bus.FLUSH) begin
      disc_d = inflt_q - CW'(rsp_ok);
    end else if (rsp_ok && (disc_q != '0)) begin
      disc_d = disc_q - CW'(1);
    end
    if (bus.INST_RVALID && (inflt_q == '0)) begin
      proto_err_d = 1'b1;
    end
    if (pop) begin
      last_pc_d = head.pc;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc_q        <= START_ADDR;
      last_pc_q   <= START_ADDR;
      inflt_q     <= '0;
      disc_q      <= '0;
      proto_err_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      last_pc_q   <= last_pc_d;
      inflt_q     <= inflt_d;
      disc_q      <= disc_d;
      proto_err_q <= proto_err_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .CW    (OW)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (push),
    .pop   (pop),
    .clear (bus.FLUSH),
    .din   (push_ent),
    .dout  (head),
    .count (occ)
  );

  assign bus.INST_RDEN   = rden;
  assign bus.INST_RIADDR = pc_q;
  assign bus.FETCH_VALID = valid;
  assign bus.FETCH_PC    = valid ? head.pc : last_pc_q;
  assign bus.FETCH_INST  = valid ? head.inst : NOP_INST;
  assign bus.PROTO_ERR   = proto_err_q;

endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed bench for fetch_prefetch with an in-order 1-cycle MMU model.
// Responses can be held back (mmu_en=0) to build up in-flight requests.
module tb_fetch_prefetch;

  logic clk;
  logic rst;
  bit   mmu_en;
  int   n_vec;
  int   n_err;
  logic [31:0] q[$];

  fetch_prefetch_if bus ();

  fetch_prefetch dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: note request/response handshakes, advance, present next response
  task automatic tick();
    logic acc;
    logic rv;
    logic [31:0] a;
    #1;
    acc = bus.INST_RDEN && !bus.MEM_WAIT;
    rv  = bus.INST_RVALID;
    a   = bus.INST_RIADDR;
    @(posedge clk);
    #1;
    if (rv && q.size() > 0) void'(q.pop_front());
    if (acc) q.push_back(a);
    if (mmu_en && q.size() > 0) begin
      bus.INST_RVALID = 1'b1;
      bus.INST_ROADDR = q[0];
      bus.INST_RDATA  = q[0] ^ 32'hDEAD_0000;
    end else begin
      bus.INST_RVALID = 1'b0;
      bus.INST_ROADDR = '0;
      bus.INST_RDATA  = '0;
    end
    @(negedge clk);
  endtask

  task automatic wait_valid(input string tag);
    int k;
    k = 0;
    while (!bus.FETCH_VALID && k < 12) begin
      tick();
      k++;
    end
    chk(tag, bus.FETCH_VALID, 1);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    mmu_en = 1'b1;
    bus.FLUSH = 1'b0;
    bus.FLUSH_PC = '0;
    bus.STALL = 1'b0;
    bus.MEM_WAIT = 1'b1;
    bus.INST_RVALID = 1'b0;
    bus.INST_ROADDR = '0;
    bus.INST_RDATA = '0;
    repeat (2) @(negedge clk);

    chk("rst_rden", bus.INST_RDEN, 0);
    chk("rst_valid", bus.FETCH_VALID, 0);
    chk("rst_inst", bus.FETCH_INST, 32'h0000_0013);
    chk("rst_pc", bus.FETCH_PC, 32'h2000_0000);
    chk("rst_perr", bus.PROTO_ERR, 0);

    // spurious response with nothing in flight
    rst = 1'b0;
    bus.INST_RVALID = 1'b1;
    bus.INST_ROADDR = 32'h0000_1234;
    #1;
    chk("sp_rden", bus.INST_RDEN, 1);
    chk("sp_addr", bus.INST_RIADDR, 32'h2000_0000);
    tick();
    chk("sp_perr", bus.PROTO_ERR, 1);
    chk("sp_valid", bus.FETCH_VALID, 0);
    chk("sp_addr2", bus.INST_RIADDR, 32'h2000_0000);
    rst = 1'b1;
    #1;
    chk("sp_perr_clr", bus.PROTO_ERR, 0);
    chk("sp_rden_rst", bus.INST_RDEN, 0);
    tick();
    rst = 1'b0;
    bus.MEM_WAIT = 1'b0;
    #1;
    chk("st_rden", bus.INST_RDEN, 1);

    // sequential stream
    tick();
    chk("st_nv1", bus.FETCH_VALID, 0);
    tick();
    chk("st_inst0", bus.FETCH_INST, 32'hFEAD_0000);
    for (int i = 0; i < 4; i++) begin
      chk("st_pc", bus.FETCH_PC, 32'h2000_0000 + 32'(4 * i));
      tick();
    end

    // stall fills buffer
    bus.STALL = 1'b1;
    repeat (10) tick();
    chk("stl_rden", bus.INST_RDEN, 0);
    chk("stl_valid", bus.FETCH_VALID, 1);
    chk("stl_addr", bus.INST_RIADDR, 32'h2000_0020);
    bus.STALL = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("stl_pc", bus.FETCH_PC, 32'h2000_0010 + 32'(4 * i));
      tick();
    end

    // MEM_WAIT freezes pc
    chk("mw_addr0", bus.INST_RIADDR, 32'h2000_002C);
    bus.MEM_WAIT = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mw_addr", bus.INST_RIADDR, 32'h2000_002C);
    end
    chk("mw_empty", bus.FETCH_VALID, 0);
    chk("mw_lastpc", bus.FETCH_PC, 32'h2000_0028);
    chk("mw_nop", bus.FETCH_INST, 32'h0000_0013);
    bus.MEM_WAIT = 1'b0;
    tick();
    chk("mw_resume", bus.INST_RIADDR, 32'h2000_0030);

    // flush with two requests in flight
    mmu_en = 1'b0;
    tick();
    tick();
    chk("fl_rden_cap", bus.INST_RDEN, 0);
    bus.FLUSH = 1'b1;
    bus.FLUSH_PC = 32'h2000_0100;
    #1;
    chk("fl_rden", bus.INST_RDEN, 0);
    tick();
    bus.FLUSH = 1'b0;
    mmu_en = 1'b1;
    wait_valid("fl_wait");
    chk("fl_pc0", bus.FETCH_PC, 32'h2000_0100);
    tick();
    chk("fl_pc1", bus.FETCH_PC, 32'h2000_0104);

    // flush colliding with a response and stall
    bus.STALL = 1'b1;
    bus.FLUSH = 1'b1;
    bus.FLUSH_PC = 32'h2000_0200;
    tick();
    chk("fc_valid", bus.FETCH_VALID, 0);
    chk("fc_pc", bus.FETCH_PC, 32'h2000_0100);
    chk("fc_nop", bus.FETCH_INST, 32'h0000_0013);
    bus.STALL = 1'b0;
    bus.FLUSH = 1'b0;
    #1;
    chk("fc_rden", bus.INST_RDEN, 1);
    wait_valid("fc_wait");
    chk("fc_pc0", bus.FETCH_PC, 32'h2000_0200);

    // back-to-back flush
    bus.FLUSH = 1'b1;
    bus.FLUSH_PC = 32'h2000_0300;
    tick();
    bus.FLUSH_PC = 32'h2000_0400;
    tick();
    bus.FLUSH = 1'b0;
    wait_valid("bb_wait");
    chk("bb_pc", bus.FETCH_PC, 32'h2000_0400);

    // 32-bit pc wrap
    bus.FLUSH = 1'b1;
    bus.FLUSH_PC = 32'hFFFF_FFF8;
    tick();
    bus.FLUSH = 1'b0;
    wait_valid("wr_wait");
    chk("wr_pc0", bus.FETCH_PC, 32'hFFFF_FFF8);
    tick();
    chk("wr_pc1", bus.FETCH_PC, 32'hFFFF_FFFC);
    tick();
    chk("wr_pc2", bus.FETCH_PC, 32'h0000_0000);

    // reset mid-fetch
    rst = 1'b1;
    #1;
    chk("mr_rden", bus.INST_RDEN, 0);
    chk("mr_valid", bus.FETCH_VALID, 0);
    chk("mr_inst", bus.FETCH_INST, 32'h0000_0013);
    chk("mr_pc", bus.FETCH_PC, 32'h2000_0000);
    chk("mr_addr", bus.INST_RIADDR, 32'h2000_0000);
    chk("mr_perr", bus.PROTO_ERR, 0);
    q.delete();
    bus.INST_RVALID = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk("mr_valid2", bus.FETCH_VALID, 1);
    chk("mr_pc2", bus.FETCH_PC, 32'h2000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
